arb_requester: RTL

//   Client-side counterpart of the two-port req/gnt arbiter. Queues commands, raises req,

---
 rtl/arb_pkg.sv | 21 ++
 rtl/arb_cmd_fifo.sv | 50 +++++
 rtl/arb_requester.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/arb_pkg.sv
// Shared types for the arbiter requester: FSM state encoding, default command
// layout and the timeout counter width.
package arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_XFER,
    ST_RELEASE
  } state_t;

  localparam int unsigned CMD_ADDR_W = 8;
  localparam int unsigned CMD_LEN_W  = 4;
  localparam int unsigned TIMEOUT_W  = 16;

  typedef struct packed {
    logic [CMD_ADDR_W-1:0] addr;
    logic [CMD_LEN_W-1:0]  len;
  } cmd_t;

endpackage

// File: rtl/arb_cmd_fifo.sv
// Synchronous command FIFO; push while full is accepted only alongside a pop.
module arb_cmd_fifo
  import arb_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter type entry_t = cmd_t
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   push,
  input  entry_t                 wr_data,
  input  logic                   pop,
  output entry_t                 rd_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  entry_t           mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/arb_requester.sv
// Arbiter client: queues commands, requests the bus, issues one burst per grant.
// Optional REQ-state timeout abort is enabled by defining ARB_REQ_TIMEOUT_EN.
module arb_requester
  import arb_pkg::*;
#(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned LEN_W   = 4,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  output logic              req,
  input  logic              gnt,
  output logic              bus_valid,
  output logic [ADDR_W-1:0] bus_addr,
  output logic              bus_last,
  output logic              busy,
  output logic              timeout_err
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [LEN_W-1:0]  len;
  } cmd_w_t;

  state_t           state;
  state_t           state_nxt;
  logic [LEN_W-1:0] beat;
  cmd_w_t           wr_cmd;
  cmd_w_t           head;
  logic             push;
  logic             pop;
  logic             full;
  logic             empty;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_nxt;
  logic             last_hit;
  logic             tmo_hit;

  assign cmd_ready = !full;
  assign push      = cmd_valid && !full;
  assign wr_cmd    = '{addr: cmd_addr, len: cmd_len};
  assign last_hit  = (state == ST_XFER) && gnt && (beat == head.len);
  assign pop       = last_hit || tmo_hit;
  assign count_nxt = count + CNT_W'(push) - CNT_W'(pop);

  arb_cmd_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (cmd_w_t)
  ) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .push    (push),
    .wr_data (wr_cmd),
    .pop     (pop),
    .rd_data (head),
    .full    (full),
    .empty   (empty),
    .count   (count)
  );

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:    if (!empty) state_nxt = ST_REQ;
      ST_REQ:     if (gnt) state_nxt = ST_XFER;
                  else if (tmo_hit) state_nxt = ST_RELEASE;
      ST_XFER:    if (last_hit) state_nxt = ST_RELEASE;
      ST_RELEASE: state_nxt = ST_IDLE;
    endcase
  end

  // Registered outputs describe the state being entered, so req is already low
  // while the final beat is on the bus; RELEASE plus IDLE form the req gap.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= ST_IDLE;
      req       <= 1'b0;
      bus_valid <= 1'b0;
      bus_last  <= 1'b0;
      bus_addr  <= '0;
      busy      <= 1'b0;
      beat      <= '0;
    end else begin
      state     <= state_nxt;
      busy      <= (state_nxt != ST_IDLE) || (count_nxt != '0);
      bus_valid <= 1'b0;
      bus_last  <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (!empty) req <= 1'b1;
        end
        ST_REQ: begin
          if (gnt) beat <= '0;
          else if (tmo_hit) req <= 1'b0;
        end
        ST_XFER: begin
          if (gnt) begin
            bus_valid <= 1'b1;
            bus_addr  <= head.addr + ADDR_W'(beat);
            beat      <= beat + LEN_W'(1);
            if (beat == head.len) begin
              bus_last <= 1'b1;
              req      <= 1'b0;
            end
          end
        end
        ST_RELEASE: begin
          beat <= '0;
        end
      endcase
    end
  end

`ifdef ARB_REQ_TIMEOUT_EN
  logic [TIMEOUT_W-1:0] tmo_cnt;

  assign tmo_hit = (state == ST_REQ) && !gnt && (tmo_cnt == TIMEOUT_W'(TIMEOUT - 1));

  always_ff @(posedge clock) begin
    if (reset) begin
      tmo_cnt     <= '0;
      timeout_err <= 1'b0;
    end else begin
      tmo_cnt     <= (state == ST_REQ) ? tmo_cnt + TIMEOUT_W'(1) : '0;
      timeout_err <= tmo_hit;
    end
  end
`else
  assign tmo_hit     = 1'b0;
  assign timeout_err = 1'b0;
`endif

endmodule
